// File: rtl/counter.sv
// Up/down counter with parallel load and synchronous reset.
// Priority on each rising edge is reset, then load, then count in the direction set by up.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] count
);

  // Reset and load are tested first, so a don't-care up or load_data cannot reach count
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_data;
    end else if (up) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: each driven cycle queues its expected count,
// which is popped and compared just after the rising edge that applies it.
module tb_counter;

  logic       clock;
  logic       reset;
  logic       load;
  logic       up;
  logic [3:0] load_data;
  logic [3:0] count;

  logic [3:0] expQueue[$];
  int         checkCount;
  int         errorCount;

  counter #(.WIDTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .up        (up),
    .load_data (load_data),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [3:0] actual,
                             input logic [3:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: count=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle on the falling edge, then check just after the next rising edge
  task automatic applyStimulus(input string tag, input logic r, input logic l,
                               input logic u, input logic [3:0] d,
                               input logic [3:0] expected);
    logic [3:0] exp;
    @(negedge clock);
    reset     = r;
    load      = l;
    up        = u;
    load_data = d;
    expQueue.push_back(expected);
    @(posedge clock);
    #1;
    if (expQueue.size() == 0) begin
      errorCount++;
      $display("[TB] FAIL %s: scoreboard empty", tag);
    end else begin
      exp = expQueue.pop_front();
      checkOutput(tag, count, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] upSeq[5];
    logic [3:0] downSeq[5];
    logic [3:0] wrapSeq[3];
    int         v;

    checkCount = 0;
    errorCount = 0;
    reset      = 1'b0;
    load       = 1'b0;
    up         = 1'b0;
    load_data  = 4'd0;

    upSeq   = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    downSeq = '{4'd11, 4'd10, 4'd9, 4'd8, 4'd7};
    wrapSeq = '{4'd15, 4'd0, 4'd1};

    applyStimulus("reset_x", 1'b1, 1'bx, 1'bx, 4'bxxxx, 4'd0);
    applyStimulus("load7_down", 1'b0, 1'b1, 1'b0, 4'd7, 4'd7);
    applyStimulus("load7_over_up", 1'b0, 1'b1, 1'b1, 4'd7, 4'd7);

    for (int i = 0; i < 5; i++)
      applyStimulus("count_up", 1'b0, 1'b0, 1'b1, 4'd3, upSeq[i]);

    for (int i = 0; i < 5; i++)
      applyStimulus("count_down", 1'b0, 1'b0, 1'b0, 4'd3, downSeq[i]);

    // From 7, fifteen more decrements pass through 0 and 15 and end at 8
    for (int k = 1; k <= 15; k++) begin
      v = 7 - k;
      if (v < 0) v = v + 16;
      applyStimulus("down_wrap", 1'b0, 1'b0, 1'b0, 4'd0, 4'(v));
    end

    applyStimulus("load14", 1'b0, 1'b1, 1'b0, 4'd14, 4'd14);
    for (int i = 0; i < 3; i++)
      applyStimulus("up_wrap", 1'b0, 1'b0, 1'b1, 4'd0, wrapSeq[i]);

    applyStimulus("reset_over_load", 1'b1, 1'b1, 1'b1, 4'd9, 4'd0);

    applyStimulus("load4", 1'b0, 1'b1, 1'b0, 4'd4, 4'd4);
    applyStimulus("up_to5", 1'b0, 1'b0, 1'b1, 4'd0, 4'd5);
    applyStimulus("reset_mid", 1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    applyStimulus("resume_1", 1'b0, 1'b0, 1'b1, 4'd0, 4'd1);
    applyStimulus("resume_2", 1'b0, 1'b0, 1'b1, 4'd0, 4'd2);
    applyStimulus("dir_flip", 1'b0, 1'b0, 1'b0, 4'd0, 4'd1);
    applyStimulus("down_to0", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus("down_to15", 1'b0, 1'b0, 1'b0, 4'd0, 4'd15);
    applyStimulus("release_load", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus("load_after_reset", 1'b0, 1'b1, 1'b0, 4'd10, 4'd10);

    if (expQueue.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQueue.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
